// File: rtl/bw_io_ddr_vref_pkg.sv
// Shared types and defaults for the DDR Vref code sequencer.
package bw_io_ddr_vref_pkg;

    localparam int unsigned VREF_W = 8;
    localparam logic [VREF_W-1:0] VREF_RST_CODE = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StSettle,
        StDone
    } vref_state_e;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bw_io_ddr_vref_if.sv
// Request/ack and Vref output bundle between the training logic and the Vref sequencer.
interface bw_io_ddr_vref_if
    import bw_io_ddr_vref_pkg::*;
#(
    parameter int unsigned W = VREF_W
);
    logic         upd_req;
    logic [W-1:0] upd_code;
    logic         upd_ack;
    logic         freeze;
    logic [W-1:0] vref_code;
    logic         busy;
    logic         done;

    modport master (
        output upd_req,
        output upd_code,
        output freeze,
        input  upd_ack,
        input  vref_code,
        input  busy,
        input  done
    );

    modport slave (
        input  upd_req,
        input  upd_code,
        input  freeze,
        output upd_ack,
        output vref_code,
        output busy,
        output done
    );
endinterface

// File: rtl/bw_io_ddr_vref_tmr.sv
// Loadable down-counter with hold; tc_o is high while the count sits at zero.
module bw_io_ddr_vref_tmr #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic             hold_i,
    output logic             tc_o
);
    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/bw_io_ddr_vref_ctl.sv
// DDR Vref code sequencer: accepts a target code, slews one LSB per STEP_CYC cycles,
// waits SETTLE_CYC cycles, then pulses done.
module bw_io_ddr_vref_ctl
    import bw_io_ddr_vref_pkg::*;
#(
    parameter int unsigned W          = VREF_W,
    parameter logic [W-1:0] RST_CODE  = VREF_RST_CODE,
    parameter int unsigned STEP_CYC   = 16,
    parameter int unsigned SETTLE_CYC = 64
) (
    input logic              clk,
    input logic              rst_l,
    bw_io_ddr_vref_if.slave  vif
);
    localparam int unsigned StepW = cnt_width(STEP_CYC);
    localparam int unsigned SetW  = cnt_width(SETTLE_CYC);
    localparam logic [StepW-1:0] StepLoad = StepW'(STEP_CYC - 1);
    localparam logic [SetW-1:0]  SetLoad  = SetW'(SETTLE_CYC - 1);

    vref_state_e  state_d, state_q;
    logic [W-1:0] code_d, code_q;
    logic [W-1:0] tgt_d, tgt_q;
    logic         ack_d, ack_q;
    logic         step_load, set_load;
    logic         step_tc, set_tc;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        tgt_d     = tgt_q;
        ack_d     = 1'b0;
        step_load = 1'b0;
        set_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vif.upd_req) begin
                    tgt_d     = vif.upd_code;
                    ack_d     = 1'b1;
                    step_load = 1'b1;
                    state_d   = StStep;
                end
            end
            StStep: begin
                // Direction comes from comparison, so the code never wraps past a rail.
                if (step_tc && !vif.freeze) begin
                    if (code_q == tgt_q) begin
                        set_load = 1'b1;
                        state_d  = StSettle;
                    end else begin
                        step_load = 1'b1;
                        code_d    = (tgt_q > code_q) ? code_q + W'(1) : code_q - W'(1);
                    end
                end
            end
            StSettle: begin
                if (set_tc && !vif.freeze) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= StIdle;
            code_q  <= RST_CODE;
            tgt_q   <= RST_CODE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tgt_q   <= tgt_d;
            ack_q   <= ack_d;
        end
    end

    bw_io_ddr_vref_tmr #(
        .Width (StepW)
    ) u_step_tmr (
        .clk        (clk),
        .rst_l      (rst_l),
        .load_i     (step_load),
        .load_val_i (StepLoad),
        .en_i       (state_q == StStep),
        .hold_i     (vif.freeze),
        .tc_o       (step_tc)
    );

    bw_io_ddr_vref_tmr #(
        .Width (SetW)
    ) u_settle_tmr (
        .clk        (clk),
        .rst_l      (rst_l),
        .load_i     (set_load),
        .load_val_i (SetLoad),
        .en_i       (state_q == StSettle),
        .hold_i     (vif.freeze),
        .tc_o       (set_tc)
    );

    assign vif.upd_ack   = ack_q;
    assign vif.vref_code = code_q;
    assign vif.busy      = (state_q != StIdle);
    assign vif.done      = (state_q == StDone);

endmodule
